router_pkt_tx: RTL and testbench
================================

// Module: router_pkt_tx
// PURPOSE
// - Source-side packet transmitter for the router input port: drives data_in/pkt_valid exactly as the router expects.
// - Payload bytes are pre-loaded into an internal buffer; on start, emits header, payload and a trailing parity byte.
// - Parity byte is sent with pkt_valid low. Stalls on router busy. Used as the traffic generator and as the host-side driver.
// PARAMETERS
// - DEPTH   64  payload buffer depth in bytes; must be >= 63 (max payload length)
// - PTR_W   6   buffer pointer width; log2(DEPTH)
// PORTS
// - clock           in   1  single clock, all logic on rising edge
// - reset           in   1  asynchronous, active-high; clears all state
// - wr_en           in   1  push wr_data into payload buffer
// - wr_data         in   8  payload byte
// - buf_full        out  1  buffer holds DEPTH bytes; writes ignored
// - buf_count       out  PTR_W+1  bytes currently buffered
// - start           in   1  request transmission; sampled only in IDLE
// - dest_addr       in   2  destination port; 2'b11 is invalid
// - pay_len         in   6  payload length in bytes, 1..63
// - corrupt_parity  in   1  sampled with start; sends inverted parity byte
// - busy            in   1  router busy; current byte is held while high
// - data_out        out  8  byte to router data_in
// - pkt_valid       out  1  high for header and payload bytes, low for parity
// - tx_active       out  1  high from header cycle through parity cycle
// - done            out  1  one-cycle pulse after parity byte accepted
// - reject          out  1  one-cycle pulse when a start is refused
// BEHAVIOUR
// - Reset: state IDLE, buffer empty, data_out=8'h00, pkt_valid=0, tx_active=0, done=0, reject=0, parity accumulator=0.
// - Byte acceptance: the byte on data_out is consumed at a rising edge where tx_active=1 and busy=0; otherwise data_out/pkt_valid hold.
// - FSM: IDLE -> HEADER -> PAYLOAD -> PARITY -> IDLE.
// - IDLE: start with dest_addr==2'b11, pay_len==0, or pay_len>buf_count -> reject=1 next cycle, stay IDLE, buffer untouched.
// - IDLE: valid start at edge T -> at T+1: data_out={pay_len,dest_addr}, pkt_valid=1, tx_active=1; parity acc loaded with header.
// - HEADER accepted -> PAYLOAD; first buffered byte presented next cycle with pkt_valid=1.
// - PAYLOAD: each accepted byte pops the buffer, XORs into parity acc, decrements remaining count; last byte accepted -> PARITY.
// - PARITY: data_out=acc (or ~acc if corrupt_parity latched), pkt_valid=0; accepted -> IDLE, done=1 for one cycle, data_out=0, tx_active=0.
// - Minimum packet: 1+pay_len+1 cycles with busy held low; back-to-back start allowed in the cycle done is high (IDLE).
// - start while not IDLE: ignored, no reject.
// - wr_en with buf_full: byte dropped. wr_en concurrent with a pop: both occur, buf_count unchanged.
// - Buffer pointers wrap modulo DEPTH; buf_count never exceeds DEPTH.
// - busy toggling mid-payload: no byte skipped or duplicated; parity covers exactly header+pay_len bytes.
// - Reset asserted mid-packet: immediate return to IDLE, pkt_valid=0, buffered bytes discarded.
// STRUCTURE
// - router_pkg: FSM state encodings (IDLE/HEADER/PAYLOAD/PARITY), ADDR_INVALID=2'b11, header field positions (addr[1:0], len[7:2]), MAX_LEN=63.
// - One sub-module: router_tx_fifo (DEPTH x 8 synchronous FIFO, async active-high reset, push/pop/full/empty/count).
// - Top holds the FSM, length counter, parity accumulator and output registers.
// TESTING
// - Load 3 bytes 8'h11,8'h22,8'h33; start addr=2'b01 len=3, busy=0 -> 8'h0D,11,22,33 with pkt_valid=1, then parity 8'h0D with pkt_valid=0, done 1 cycle.
// - Same packet, busy high for 4 cycles during byte 8'h22 -> 8'h22 held 5 cycles, sequence and parity unchanged.
// - start addr=2'b11 or len=5 with 3 bytes buffered -> reject pulse, pkt_valid stays 0, buf_count stays 3.
// - corrupt_parity=1 on the first packet -> parity byte 8'hF2; next packet without it sends correct parity.
// - Fill 64 bytes, write 65th -> buf_full=1, byte dropped; send len=63 while writing -> count tracks pushes minus pops.
// - Assert reset after 2 payload bytes of a len=10 packet -> outputs zero same cycle, buf_count=0, next start rejected.

Source files
------------

// File: rtl/router_pkt_tx_pkg.sv
// Shared types and constants for the router packet transmitter.
// The header byte carries the destination in bits [1:0] and the payload length in bits [7:2].
package router_pkt_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HEADER  = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_PARITY  = 2'd3
   } tx_state_t;

   localparam logic [1:0] ADDR_INVALID = 2'b11;
   localparam int HDR_ADDR_LSB = 0;
   localparam int HDR_ADDR_MSB = 1;
   localparam int HDR_LEN_LSB  = 2;
   localparam int HDR_LEN_MSB  = 7;
   localparam int MAX_LEN      = 63;

   function automatic logic [7:0] make_header(input logic [5:0] len, input logic [1:0] addr);
      logic [7:0] hdr;
      hdr = '0;
      hdr[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
      hdr[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
      return hdr;
   endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Host-side and router-side signals of the packet transmitter.
// master is the host/router side, slave is the transmitter itself.
interface router_pkt_tx_if #(
   parameter int PTR_W = 6
);
   logic             wr_en;
   logic [7:0]       wr_data;
   logic             buf_full;
   logic [PTR_W:0]   buf_count;
   logic             start;
   logic [1:0]       dest_addr;
   logic [5:0]       pay_len;
   logic             corrupt_parity;
   logic             reject;
   logic             busy;
   logic [7:0]       data_out;
   logic             pkt_valid;
   logic             tx_active;
   logic             done;

   modport master (
      output wr_en, wr_data, start, dest_addr, pay_len, corrupt_parity, busy,
      input  buf_full, buf_count, reject, data_out, pkt_valid, tx_active, done
   );

   modport slave (
      input  wr_en, wr_data, start, dest_addr, pay_len, corrupt_parity, busy,
      output buf_full, buf_count, reject, data_out, pkt_valid, tx_active, done
   );
endinterface

// File: rtl/router_pkt_tx_fifo.sv
// DEPTH x 8 payload FIFO. Exposes the head byte and the byte behind it so the
// transmitter can load its output register with the next byte in the same cycle it pops.
module router_pkt_tx_fifo #(
   parameter int DEPTH = 64,
   parameter int PTR_W = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [7:0]       push_data,
   input  logic             pop,
   output logic [7:0]       head_data,
   output logic [7:0]       next_data,
   output logic             full,
   output logic             empty,
   output logic [PTR_W:0]   count
);
   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W:0]   count_reg;
   logic             push_ok;
   logic             pop_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full      = (count_reg == (PTR_W+1)'(DEPTH));
   assign empty     = (count_reg == '0);
   assign count     = count_reg;
   assign push_ok   = push & ~full;
   assign pop_ok    = pop & ~empty;
   assign head_data = mem[rd_ptr_reg];
   assign next_data = mem[ptr_inc(rd_ptr_reg)];

   always_ff @(posedge clock) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         end
         if (pop_ok) begin
            rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         end
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
            2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end
endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter: emits header, buffered payload and a parity byte to the router
// input port, holding the current byte whenever the router signals busy.
module router_pkt_tx
   import router_pkt_tx_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int PTR_W = 6
) (
   input  logic           clock,
   input  logic           reset,
   router_pkt_tx_if.slave bus
);
   localparam int LEN_W = $clog2(MAX_LEN + 1);

   tx_state_t        state_reg;
   logic [LEN_W-1:0] remain_reg;
   logic [7:0]       acc_reg;
   logic [7:0]       data_out_reg;
   logic             corrupt_reg;
   logic             pkt_valid_reg;
   logic             tx_active_reg;
   logic             done_reg;
   logic             reject_reg;

   logic [7:0]       fifo_head;
   logic [7:0]       fifo_next;
   logic             fifo_full;
   logic             fifo_empty;
   logic [PTR_W:0]   fifo_count;
   logic             fifo_pop;
   logic             accept;
   logic             start_bad;
   logic [7:0]       header_byte;

   assign accept      = tx_active_reg & ~bus.busy;
   assign fifo_pop    = (state_reg == ST_PAYLOAD) && accept && !fifo_empty;
   assign header_byte = make_header(bus.pay_len, bus.dest_addr);
   assign start_bad   = (bus.dest_addr == ADDR_INVALID) || (bus.pay_len == '0) ||
                        ((PTR_W+1)'(bus.pay_len) > fifo_count);

   router_pkt_tx_fifo #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (bus.wr_en),
      .push_data (bus.wr_data),
      .pop       (fifo_pop),
      .head_data (fifo_head),
      .next_data (fifo_next),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         remain_reg    <= '0;
         acc_reg       <= '0;
         data_out_reg  <= '0;
         corrupt_reg   <= 1'b0;
         pkt_valid_reg <= 1'b0;
         tx_active_reg <= 1'b0;
         done_reg      <= 1'b0;
         reject_reg    <= 1'b0;
      end else begin
         done_reg   <= 1'b0;
         reject_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (bus.start) begin
                  if (start_bad) begin
                     reject_reg <= 1'b1;
                  end else begin
                     data_out_reg  <= header_byte;
                     acc_reg       <= header_byte;
                     remain_reg    <= LEN_W'(bus.pay_len);
                     corrupt_reg   <= bus.corrupt_parity;
                     pkt_valid_reg <= 1'b1;
                     tx_active_reg <= 1'b1;
                     state_reg     <= ST_HEADER;
                  end
               end
            end
            ST_HEADER: begin
               if (accept) begin
                  data_out_reg <= fifo_head;
                  state_reg    <= ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               if (accept) begin
                  acc_reg    <= acc_reg ^ data_out_reg;
                  remain_reg <= remain_reg - LEN_W'(1);
                  // The byte leaving now is the last one: parity goes out next, unflagged.
                  if (remain_reg == LEN_W'(1)) begin
                     data_out_reg  <= acc_reg ^ data_out_reg ^ {8{corrupt_reg}};
                     pkt_valid_reg <= 1'b0;
                     state_reg     <= ST_PARITY;
                  end else begin
                     data_out_reg <= fifo_next;
                  end
               end
            end
            ST_PARITY: begin
               if (accept) begin
                  data_out_reg  <= '0;
                  tx_active_reg <= 1'b0;
                  done_reg      <= 1'b1;
                  state_reg     <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign bus.data_out  = data_out_reg;
   assign bus.pkt_valid = pkt_valid_reg;
   assign bus.tx_active = tx_active_reg;
   assign bus.done      = done_reg;
   assign bus.reject    = reject_reg;
   assign bus.buf_full  = fifo_full;
   assign bus.buf_count = fifo_count;
endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: packet sequencing, busy stalls, rejects,
// corrupted parity, buffer full behaviour and reset mid-packet.
`timescale 1ns/1ps
module tb_router_pkt_tx;
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   router_pkt_tx_if #(.PTR_W(6)) bus();

   router_pkt_tx #(.DEPTH(64), .PTR_W(6)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] cap_data  [0:79];
   logic       cap_valid [0:79];
   int         cap_hold  [0:79];
   int         cap_n;
   int         cap_cycles;
   bit         saw_done;
   bit         cap_stable;

   logic [7:0] exp_pkt   [0:4] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
   logic       exp_valid [0:4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   logic [1:0] rej_addr  [0:2] = '{2'b11, 2'b01, 2'b00};
   logic [5:0] rej_len   [0:2] = '{6'd3, 6'd5, 6'd0};

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic load(input logic [7:0] b);
      bus.wr_en = 1'b1;
      bus.wr_data = b;
      step();
      bus.wr_en = 1'b0;
   endtask

   task automatic do_start(input logic [1:0] a, input logic [5:0] l, input logic c);
      bus.start = 1'b1;
      bus.dest_addr = a;
      bus.pay_len = l;
      bus.corrupt_parity = c;
      step();
      bus.start = 1'b0;
      bus.corrupt_parity = 1'b0;
   endtask

   // Drives busy and records every accepted byte until done pulses (bounded).
   task automatic run_tx(input int busy_idx, input int busy_cycles);
      int k;
      int held;
      k = 0;
      held = 0;
      cap_n = 0;
      cap_cycles = 0;
      saw_done = 1'b0;
      cap_stable = 1'b1;
      for (int g = 0; g < 300 && !saw_done; g++) begin
         if (bus.tx_active && k < 80) begin
            bus.busy = (k == busy_idx) && (held < busy_cycles);
            if (held == 0) begin
               cap_data[k] = bus.data_out;
               cap_valid[k] = bus.pkt_valid;
            end else if (bus.data_out !== cap_data[k] || bus.pkt_valid !== cap_valid[k]) begin
               cap_stable = 1'b0;
            end
            cap_cycles++;
            step();
            if (bus.busy) begin
               held++;
            end else begin
               cap_hold[k] = held + 1;
               k++;
               held = 0;
            end
         end else begin
            step();
         end
         saw_done = bus.done;
      end
      bus.busy = 1'b0;
      cap_n = k;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      vectors++; if (bus.data_out !== 8'h00) begin miscompares++; $display("FAIL reset_data_out got %h want 00", bus.data_out); end
      vectors++; if (bus.pkt_valid !== 1'b0) begin miscompares++; $display("FAIL reset_pkt_valid got %b want 0", bus.pkt_valid); end
      vectors++; if (bus.tx_active !== 1'b0) begin miscompares++; $display("FAIL reset_tx_active got %b want 0", bus.tx_active); end
      vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", bus.done); end
      vectors++; if (bus.reject !== 1'b0) begin miscompares++; $display("FAIL reset_reject got %b want 0", bus.reject); end
      vectors++; if (bus.buf_count !== 7'd0) begin miscompares++; $display("FAIL reset_buf_count got %0d want 0", bus.buf_count); end
      vectors++; if (bus.buf_full !== 1'b0) begin miscompares++; $display("FAIL reset_buf_full got %b want 0", bus.buf_full); end
      reset = 1'b0;
      step();
      vectors++; if (bus.tx_active !== 1'b0) begin miscompares++; $display("FAIL idle_tx_active got %b want 0", bus.tx_active); end
   endtask

   task automatic test_basic();
      load(8'h11); load(8'h22); load(8'h33);
      vectors++; if (bus.buf_count !== 7'd3) begin miscompares++; $display("FAIL basic_count got %0d want 3", bus.buf_count); end
      do_start(2'b01, 6'd3, 1'b0);
      run_tx(-1, 0);
      $display("basic packet: %0d bytes in %0d cycles, done=%0b", cap_n, cap_cycles, saw_done);
      vectors++; if (cap_n !== 5) begin miscompares++; $display("FAIL basic_nbytes got %0d want 5", cap_n); end
      for (int i = 0; i < 5; i++) begin
         vectors++; if (cap_data[i] !== exp_pkt[i] || cap_valid[i] !== exp_valid[i]) begin miscompares++; $display("FAIL basic_byte%0d got %h/%b want %h/%b", i, cap_data[i], cap_valid[i], exp_pkt[i], exp_valid[i]); end
      end
      vectors++; if (cap_cycles !== 5) begin miscompares++; $display("FAIL basic_cycles got %0d want 5", cap_cycles); end
      vectors++; if (saw_done !== 1'b1) begin miscompares++; $display("FAIL basic_done got %b want 1", saw_done); end
      vectors++; if (bus.data_out !== 8'h00 || bus.tx_active !== 1'b0) begin miscompares++; $display("FAIL basic_after got %h/%b want 00/0", bus.data_out, bus.tx_active); end
      vectors++; if (bus.buf_count !== 7'd0) begin miscompares++; $display("FAIL basic_count_end got %0d want 0", bus.buf_count); end
      step();
      vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL basic_done_pulse got %b want 0", bus.done); end
   endtask

   task automatic test_busy();
      load(8'h11); load(8'h22); load(8'h33);
      do_start(2'b01, 6'd3, 1'b0);
      run_tx(2, 4);
      $display("busy packet: %0d bytes, byte 22 held %0d cycles", cap_n, cap_hold[2]);
      vectors++; if (cap_n !== 5) begin miscompares++; $display("FAIL busy_nbytes got %0d want 5", cap_n); end
      for (int i = 0; i < 5; i++) begin
         vectors++; if (cap_data[i] !== exp_pkt[i] || cap_valid[i] !== exp_valid[i]) begin miscompares++; $display("FAIL busy_byte%0d got %h/%b want %h/%b", i, cap_data[i], cap_valid[i], exp_pkt[i], exp_valid[i]); end
      end
      vectors++; if (cap_hold[2] !== 5) begin miscompares++; $display("FAIL busy_hold got %0d want 5", cap_hold[2]); end
      vectors++; if (cap_hold[3] !== 1) begin miscompares++; $display("FAIL busy_hold_next got %0d want 1", cap_hold[3]); end
      vectors++; if (cap_stable !== 1'b1) begin miscompares++; $display("FAIL busy_stable got %b want 1", cap_stable); end
      vectors++; if (saw_done !== 1'b1) begin miscompares++; $display("FAIL busy_done got %b want 1", saw_done); end
   endtask

   task automatic test_reject();
      load(8'h11); load(8'h22); load(8'h33);
      for (int i = 0; i < 3; i++) begin
         do_start(rej_addr[i], rej_len[i], 1'b0);
         $display("reject try addr=%b len=%0d: reject=%b count=%0d", rej_addr[i], rej_len[i], bus.reject, bus.buf_count);
         vectors++; if (bus.reject !== 1'b1) begin miscompares++; $display("FAIL reject%0d_pulse got %b want 1", i, bus.reject); end
         vectors++; if (bus.pkt_valid !== 1'b0 || bus.tx_active !== 1'b0) begin miscompares++; $display("FAIL reject%0d_idle got %b/%b want 0/0", i, bus.pkt_valid, bus.tx_active); end
         vectors++; if (bus.buf_count !== 7'd3) begin miscompares++; $display("FAIL reject%0d_count got %0d want 3", i, bus.buf_count); end
         step();
         vectors++; if (bus.reject !== 1'b0) begin miscompares++; $display("FAIL reject%0d_clear got %b want 0", i, bus.reject); end
      end
   endtask

   task automatic test_corrupt_back_to_back();
      load(8'h11); load(8'h22); load(8'h33);
      do_start(2'b01, 6'd3, 1'b1);
      run_tx(-1, 0);
      $display("corrupt packet: parity %h done=%0b", cap_data[4], saw_done);
      vectors++; if (cap_data[4] !== 8'hF2 || cap_valid[4] !== 1'b0) begin miscompares++; $display("FAIL corrupt_parity got %h/%b want f2/0", cap_data[4], cap_valid[4]); end
      vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL corrupt_done got %b want 1", bus.done); end
      do_start(2'b01, 6'd3, 1'b0);
      vectors++; if (bus.data_out !== 8'h0D || bus.pkt_valid !== 1'b1 || bus.tx_active !== 1'b1) begin miscompares++; $display("FAIL b2b_header got %h/%b/%b want 0d/1/1", bus.data_out, bus.pkt_valid, bus.tx_active); end
      run_tx(-1, 0);
      $display("back-to-back packet: %0d bytes, parity %h", cap_n, cap_data[4]);
      vectors++; if (cap_n !== 5) begin miscompares++; $display("FAIL b2b_nbytes got %0d want 5", cap_n); end
      for (int i = 1; i < 5; i++) begin
         vectors++; if (cap_data[i] !== exp_pkt[i]) begin miscompares++; $display("FAIL b2b_byte%0d got %h want %h", i, cap_data[i], exp_pkt[i]); end
      end
      vectors++; if (bus.buf_count !== 7'd0) begin miscompares++; $display("FAIL b2b_count got %0d want 0", bus.buf_count); end
   endtask

   task automatic test_full();
      int cnt;
      int k;
      bit push;
      bit pop;
      logic [7:0] acc;
      for (int i = 1; i <= 64; i++) load(8'(i));
      vectors++; if (bus.buf_full !== 1'b1 || bus.buf_count !== 7'd64) begin miscompares++; $display("FAIL full_fill got %b/%0d want 1/64", bus.buf_full, bus.buf_count); end
      load(8'hEE);
      vectors++; if (bus.buf_full !== 1'b1 || bus.buf_count !== 7'd64) begin miscompares++; $display("FAIL full_drop got %b/%0d want 1/64", bus.buf_full, bus.buf_count); end
      do_start(2'b10, 6'd63, 1'b0);
      cnt = 64;
      k = 0;
      acc = 8'hFE;
      for (int c = 0; c < 80 && !bus.done; c++) begin
         if (k == 0) begin
            vectors++; if (bus.data_out !== 8'hFE || bus.pkt_valid !== 1'b1) begin miscompares++; $display("FAIL full_header got %h/%b want fe/1", bus.data_out, bus.pkt_valid); end
         end else if (k <= 63) begin
            vectors++; if (bus.data_out !== 8'(k) || bus.pkt_valid !== 1'b1) begin miscompares++; $display("FAIL full_byte%0d got %h/%b want %h/1", k, bus.data_out, bus.pkt_valid, 8'(k)); end
            acc = acc ^ 8'(k);
         end else begin
            vectors++; if (bus.data_out !== acc || bus.pkt_valid !== 1'b0) begin miscompares++; $display("FAIL full_parity got %h/%b want %h/0", bus.data_out, bus.pkt_valid, acc); end
         end
         bus.wr_en = (c >= 1 && c <= 20);
         bus.wr_data = 8'(8'h80 + c);
         push = bus.wr_en && (cnt < 64);
         pop = (k >= 1 && k <= 63);
         step();
         k++;
         cnt = cnt + int'(push) - int'(pop);
         vectors++; if (bus.buf_count !== 7'(cnt)) begin miscompares++; $display("FAIL full_count_c%0d got %0d want %0d", c, bus.buf_count, cnt); end
      end
      bus.wr_en = 1'b0;
      $display("len=63 packet: %0d bytes sent, buf_count=%0d", k, bus.buf_count);
      vectors++; if (k !== 65 || bus.done !== 1'b1) begin miscompares++; $display("FAIL full_end got %0d/%b want 65/1", k, bus.done); end
   endtask

   task automatic test_reset_mid();
      do_start(2'b00, 6'd10, 1'b0);
      step();
      step();
      step();
      vectors++; if (bus.pkt_valid !== 1'b1 || bus.tx_active !== 1'b1) begin miscompares++; $display("FAIL mid_inflight got %b/%b want 1/1", bus.pkt_valid, bus.tx_active); end
      #2;
      reset = 1'b1;
      #1;
      $display("reset mid-packet: data_out=%h pkt_valid=%b count=%0d", bus.data_out, bus.pkt_valid, bus.buf_count);
      vectors++; if (bus.data_out !== 8'h00 || bus.pkt_valid !== 1'b0 || bus.tx_active !== 1'b0) begin miscompares++; $display("FAIL mid_outputs got %h/%b/%b want 00/0/0", bus.data_out, bus.pkt_valid, bus.tx_active); end
      vectors++; if (bus.buf_count !== 7'd0) begin miscompares++; $display("FAIL mid_count got %0d want 0", bus.buf_count); end
      reset = 1'b0;
      step();
      do_start(2'b01, 6'd1, 1'b0);
      vectors++; if (bus.reject !== 1'b1 || bus.tx_active !== 1'b0) begin miscompares++; $display("FAIL mid_restart got %b/%b want 1/0", bus.reject, bus.tx_active); end
   endtask

   initial begin
      bus.wr_en = 1'b0;
      bus.wr_data = 8'h00;
      bus.start = 1'b0;
      bus.dest_addr = 2'b00;
      bus.pay_len = 6'd0;
      bus.corrupt_parity = 1'b0;
      bus.busy = 1'b0;
      reset = 1'b1;
      test_reset();
      test_basic();
      test_busy();
      test_reject();
      test_corrupt_back_to_back();
      test_full();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "timeout");
   end
endmodule
